// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and defaults.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package inst_loader_pkg;

    localparam int LD_DEPTH_DEFAULT = 1024;
    localparam int LD_WORD_W        = 9;
    localparam int LD_LEN_W         = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_INS_LO = 4'd3,
        ST_INS_HI = 4'd4,
        ST_WRITE  = 4'd5,
        ST_LAUNCH = 4'd6,
        ST_RUN    = 4'd7,
        ST_ERROR  = 4'd8
    } ld_state_t;

    // States in which the loader is prepared to take a byte from the stream.
    function automatic logic is_byte_state(input ld_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_INS_LO) || (s == ST_INS_HI);
    endfunction

    function automatic logic is_busy_state(input ld_state_t s);
        return (s != ST_IDLE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Byte-stream instruction loader: length header, 9-bit words into imem, then a START pulse.
// Latency: 3 cycles per word (lo byte, hi byte, write); all outputs registered.
// Backpressure: in_ready only in byte states; the FSM stalls indefinitely while in_valid is low.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH  = LD_DEPTH_DEFAULT,
    parameter int ADDR_W = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 load_go,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [LD_WORD_W-1:0] imem_wdata,
    output logic                 proc_start,
    input  logic                 proc_done,
    output logic                 busy,
    output logic                 err
);

    localparam logic [LD_LEN_W:0] DEPTH_L = (LD_LEN_W+1)'(DEPTH);

    ld_state_t             state, state_d;
    logic [LD_LEN_W-1:0]   n_q, n_d;
    logic [LD_LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]            lo_q, lo_d;
    logic [LD_LEN_W-1:0]   len_full;
    logic [LD_LEN_W-1:0]   idx_inc;
    logic [ADDR_W-1:0]     addr_d;
    logic [LD_WORD_W-1:0]  wdata_d;
    logic                  err_d;

    always_comb begin
        state_d  = state;
        n_d      = n_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        addr_d   = imem_addr;
        wdata_d  = imem_wdata;
        err_d    = err;
        len_full = {in_data, n_q[7:0]};
        idx_inc  = idx_q + 16'd1;

        unique case (state)
            ST_IDLE: begin
                if (load_go) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (in_valid) begin
                    n_d[7:0] = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (in_valid) begin
                    n_d[15:8] = in_data;
                    if ({1'b0, len_full} > DEPTH_L) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else if (len_full == '0) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_INS_LO;
                    end
                end
            end
            ST_INS_LO: begin
                if (in_valid) begin
                    lo_d    = in_data;
                    state_d = ST_INS_HI;
                end
            end
            ST_INS_HI: begin
                if (in_valid) begin
                    // Only bit 0 of the high byte is meaningful; anything else is a framing error.
                    if (in_data[7:1] != 7'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        addr_d  = ADDR_W'(idx_q);
                        wdata_d = {in_data[0], lo_q};
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? ST_LAUNCH : ST_INS_LO;
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (proc_done) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (load_go) begin
                    err_d   = 1'b0;
                    state_d = ST_LEN_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            lo_q       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            proc_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            err        <= err_d;
            in_ready   <= is_byte_state(state_d);
            imem_we    <= (state_d == ST_WRITE);
            proc_start <= (state_d == ST_LAUNCH);
            busy       <= is_busy_state(state_d);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomised directed bench for inst_loader against a byte-stream reference model.
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              reset;
    logic              load_go;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [8:0]        imem_wdata;
    logic              proc_start;
    logic              proc_done;
    logic              busy;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    wr_t wr_q[$];
    wr_t exp_wr[$];
    int  exp_consumed;
    bit  exp_err;
    int  start_cnt;
    bit  start_prev;
    bit  start_consec;

    inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .load_go    (load_go),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .proc_start (proc_start),
        .proc_done  (proc_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (imem_we === 1'b1) wr_q.push_back('{int'(imem_addr), int'(imem_wdata)});
        if (proc_start === 1'b1 && start_prev) start_consec = 1'b1;
        start_prev = (proc_start === 1'b1);
        if (proc_start === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour derived straight from the byte stream.
    task automatic model(input bq_t b);
        int n;
        exp_wr.delete();
        exp_err      = 1'b0;
        n            = int'({b[1], b[0]});
        exp_consumed = 2;
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] lo, hi;
            lo = b[2 + 2*i];
            hi = b[3 + 2*i];
            exp_consumed += 2;
            if (hi[7:1] != 7'd0) begin
                exp_err = 1'b1;
                return;
            end
            exp_wr.push_back('{i, int'({hi[0], lo})});
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset    = 1'b1;
        in_valid = 1'b0;
        load_go  = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_load_go();
        @(negedge CLK);
        load_go = 1'b1;
        @(posedge CLK);
        #1 load_go = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int budget = 0; budget < 200; budget++) begin
            @(negedge CLK);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) begin
                    @(posedge CLK);
                    #1 in_valid = 1'b0;
                    return;
                end
            end
        end
        check("send_timeout_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_session(input string name, input bq_t b, input bit gaps,
                               input bit noise_done, output int launch_lat);
        int t;
        model(b);
        wr_q.delete();
        start_cnt    = 0;
        start_consec = 1'b0;
        pulse_load_go();
        @(negedge CLK);
        check({name, "_lenlo_ready"}, 32'(in_ready), 32'd1);
        check({name, "_lenlo_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < exp_consumed; i++) begin
            if (noise_done) proc_done = 1'($urandom_range(0, 1));
            send_byte(b[i], gaps);
        end
        proc_done = 1'b0;
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (proc_start !== 1'b1 && err !== 1'b1 && t < 20);
        launch_lat = t;
        if (exp_err) begin
            check({name, "_err"}, 32'(err), 32'd1);
            check({name, "_err_ready"}, 32'(in_ready), 32'd0);
            check({name, "_err_busy"}, 32'(busy), 32'd0);
            @(negedge CLK);
            check({name, "_err_starts"}, 32'(start_cnt), 32'd0);
        end else begin
            check({name, "_start"}, 32'(proc_start), 32'd1);
            check({name, "_noerr"}, 32'(err), 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                check({name, "_run_busy"}, 32'(busy), 32'd1);
                check({name, "_run_ready"}, 32'(in_ready), 32'd0);
            end
            proc_done = 1'b1;
            @(posedge CLK);
            #1 proc_done = 1'b0;
            @(negedge CLK);
            check({name, "_idle_busy"}, 32'(busy), 32'd0);
            check({name, "_start_count"}, 32'(start_cnt), 32'd1);
            check({name, "_start_consec"}, 32'(start_consec), 32'd0);
        end
        check({name, "_write_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            check({name, "_wr_addr"}, 32'(wr_q[i].addr), 32'(exp_wr[i].addr));
            check({name, "_wr_data"}, 32'(wr_q[i].data), 32'(exp_wr[i].data));
        end
    endtask

    function automatic bq_t make_session(input int n, input bit allow_bad);
        bq_t b;
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            b.push_back(8'($urandom));
            if (allow_bad && $urandom_range(0, 9) == 0) b.push_back(8'($urandom_range(2, 255)));
            else b.push_back(8'($urandom_range(0, 1)));
        end
        return b;
    endfunction

    initial begin
        bq_t b;
        bq_t four;
        int lat;
        reset      = 1'b1;
        load_go    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        proc_done  = 1'b0;
        start_cnt  = 0;
        start_prev = 1'b0;
        do_reset();
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_proc_start", 32'(proc_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Two words, contiguous valid.
        b = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00};
        run_session("two_words", b, 1'b0, 1'b0, lat);
        check("two_words_addr0_data", 32'(wr_q.size() > 0 ? wr_q[0].data : 0), 32'h1A5);

        // Empty program launches straight after the length header.
        b = '{8'h00, 8'h00};
        run_session("empty", b, 1'b0, 1'b0, lat);
        check("empty_launch_within_2", 32'(lat <= 2), 32'd1);

        // Length one past capacity.
        b = '{8'h01, 8'h04};
        run_session("too_long", b, 1'b0, 1'b0, lat);
        pulse_load_go();
        @(negedge CLK);
        check("too_long_reload_err", 32'(err), 32'd0);
        check("too_long_reload_ready", 32'(in_ready), 32'd1);
        check("too_long_reload_busy", 32'(busy), 32'd1);
        do_reset();

        // Bad high byte on the second word.
        b = '{8'h03, 8'h00, 8'h11, 8'h01, 8'h22, 8'h02, 8'h33, 8'h00};
        run_session("bad_hi", b, 1'b0, 1'b0, lat);
        do_reset();

        // Reset while waiting for a high byte.
        pulse_load_go();
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hA5, 1'b0);
        @(negedge CLK);
        check("mid_ins_hi_ready", 32'(in_ready), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(posedge CLK);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'd0);
        check("mid_rst_wdata", 32'(imem_wdata), 32'd0);
        check("mid_rst_start", 32'(proc_start), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        b = '{8'h01, 8'h00, 8'h77, 8'h01};
        run_session("after_rst", b, 1'b0, 1'b0, lat);

        // Four words with and without gaps, proc_done noise during loading.
        four = make_session(4, 1'b0);
        run_session("four_contig", four, 1'b0, 1'b0, lat);
        run_session("four_gaps", four, 1'b1, 1'b1, lat);

        // Random sessions, some with framing errors.
        for (int s = 0; s < 8; s++) begin
            b = make_session($urandom_range(1, 7), 1'b1);
            run_session("rand", b, 1'b1, 1'b1, lat);
            if (exp_err) do_reset();
        end

        // Full-capacity program.
        b = make_session(DEPTH, 1'b0);
        run_session("full", b, 1'b0, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the instruction-memory capacity in words (max legal N).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the imem_addr width; it matches the processor PC width.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load_go  input  1  request to begin a load session.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port imem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 SHALL have port imem_wdata  output  9  instruction word written.
REQ-012 SHALL have port proc_start  output  1  one-cycle START pulse to the processor.
REQ-013 SHALL have port proc_done  input  1  processor DONE.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE and ERROR.
REQ-015 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL implement the states IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, WRITE, LAUNCH, RUN and ERROR.
REQ-017 SHALL move from IDLE to LEN_LO on load_go, and from ERROR to LEN_LO on load_go (clearing err); load_go SHALL be ignored in all other states.
REQ-018 SHALL assert in_ready only in LEN_LO, LEN_HI, INS_LO and INS_HI, and a byte SHALL transfer when in_valid and in_ready are both high at the rising edge.
REQ-019 SHALL not change state or data registers while in_valid is low in a byte state (no timeout).
REQ-020 SHALL take the LEN_LO byte as N[7:0] and the LEN_HI byte as N[15:8].
REQ-021 SHALL, after LEN_HI: go to ERROR if N > DEPTH; go to LAUNCH if N == 0; otherwise clear idx and go to INS_LO.
REQ-022 SHALL latch the INS_LO byte as word[7:0].
REQ-023 SHALL, on the INS_HI byte: go to ERROR if in_data[7:1] != 0 (no write); otherwise set word[8] = in_data[0] and go to WRITE.
REQ-024 SHALL, in WRITE (exactly one cycle), drive imem_we=1, imem_addr=idx and imem_wdata=word; idx then increments, and the next state is LAUNCH if idx+1 == N, else INS_LO.
REQ-025 SHALL drive imem_we to 0 in every state except WRITE, and imem_addr/imem_wdata SHALL hold their last values.
REQ-026 SHALL, in LAUNCH (exactly one cycle), drive proc_start=1 and then go to RUN; proc_start SHALL never be high for two consecutive cycles.
REQ-027 SHALL, in RUN, go to IDLE on proc_done=1; proc_done SHALL be ignored in every other state.
REQ-028 SHALL set err=1 on entry to ERROR and hold it until load_go or reset.
REQ-029 SHALL have a minimum throughput of 3 cycles per instruction (INS_LO, INS_HI, WRITE).
REQ-030 SHALL compare idx and N at 16-bit width; idx SHALL never wrap because N <= DEPTH.

Reset
REQ-031 SHALL, when reset is high at an edge, override every other input, including mid-session.
REQ-032 SHALL, on reset, enter IDLE and drive in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, proc_start=0, busy=0, err=0, with idx=0 and N=0.
REQ-033 SHALL leave words already written by an aborted session in memory; those words are undefined to software.

Structure
REQ-034 SHALL define the state enum ld_state_t and the constant LD_DEPTH_DEFAULT in the shared package definitions.
REQ-035 SHALL have no sub-module: a single FSM plus the idx and N counters, with registered outputs.

Verification
REQ-036 SHALL cover: reset, load_go, bytes 02 00 A5 01 3C 00 -> writes addr0=0x1A5 and addr1=0x03C, each on a single-cycle imem_we, then proc_start on one cycle, busy=1 until proc_done.
REQ-037 SHALL cover: N bytes 00 00 -> no imem_we, proc_start pulses 2 cycles after the LEN_HI transfer, then RUN, then IDLE on proc_done.
REQ-038 SHALL cover: DEPTH=1024 with N bytes 01 04 (1025) -> ERROR, err=1, in_ready=0, no writes; a following load_go clears err and in_ready returns high in LEN_LO.
REQ-039 SHALL cover: an INS_HI byte of 0x02 -> ERROR with no imem_we for that word, and idx not incremented.
REQ-040 SHALL cover: reset asserted in INS_HI mid-session -> next cycle IDLE, all outputs 0, and a new load_go restarts at addr 0.
REQ-041 SHALL cover: in_valid toggled randomly during a 4-word load -> the same writes as with contiguous valid, and proc_done pulsed before LAUNCH is ignored.
